fft8_seq: RTL and testbench

- Sequential 8-point forward FFT in Q16.16 fixed point. It is the forward companion of the team's combinational 8-point inverse FFT.
- Accepts one complex sample per cycle over a valid/ready stream, stores the frame in bit-reversed order, and runs the 12 radix-2 DIT butterflies on one shared butterfly datapath.
- Streams the 8 frequency bins out in natural order with valid/ready backpressure.
- Feeds the spectral-processing path whose output goes into the inverse FFT.

---
 rtl/fft8_seq.sv | 152 +++++++++++++++
 tb/tb_fft8_seq.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft8_seq.sv
// Sequential 8-point forward FFT, Q16.16, with one shared radix-2 DIT butterfly.
// Samples load in bit-reversed order, 12 butterflies run in place, and bins stream out in natural order.
//
// state   | meaning
// LOAD    | accept samples 0..7 into buffer[bitrev3(n)]
// COMPUTE | one butterfly per cycle, stage 0..2 x butterfly 0..3
// OUTPUT  | present buffer[k], advance k on out_valid & out_ready
module fft8_seq #(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_re,
  input  logic [DATA_W-1:0] in_im,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_last,
  output logic              busy
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  localparam logic signed [DATA_W-1:0] W_ONE  = DATA_W'(32'sh00010000);
  localparam logic signed [DATA_W-1:0] W_NONE = DATA_W'(32'shFFFF0000);
  localparam logic signed [DATA_W-1:0] W_RT   = DATA_W'(32'sh0000B504);
  localparam logic signed [DATA_W-1:0] W_NRT  = DATA_W'(32'shFFFF4AFC);

  state_t state, state_nxt;
  logic [2:0] cnt;
  logic [1:0] stage, bfly;

  logic signed [DATA_W-1:0] mem_re [8];
  logic signed [DATA_W-1:0] mem_im [8];

  logic [2:0] top, bot;
  logic [1:0] tw_k;
  logic signed [DATA_W-1:0] w_re, w_im;
  logic signed [DATA_W-1:0] a_re, a_im, b_re, b_im, t_re, t_im;

  // Full-width product, truncated (floor) back to the Q format.
  function automatic logic signed [DATA_W-1:0] qmul(input logic signed [DATA_W-1:0] x,
                                                    input logic signed [DATA_W-1:0] y);
    logic signed [2*DATA_W-1:0] p;
    p = x * y;
    return DATA_W'(p >>> FRAC_W);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD:    if (in_valid && cnt == 3'd7) state_nxt = COMPUTE;
      COMPUTE: if (stage == 2'd2 && bfly == 2'd3) state_nxt = OUTPUT;
      OUTPUT:  if (out_ready && cnt == 3'd7) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_comb begin
    in_ready  = (state == LOAD);
    out_valid = (state == OUTPUT);
    out_last  = (state == OUTPUT) && (cnt == 3'd7);
    busy      = (state != LOAD);
    out_re    = (state == OUTPUT) ? mem_re[cnt] : '0;
    out_im    = (state == OUTPUT) ? mem_im[cnt] : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= 3'd0;
      stage <= 2'd0;
      bfly  <= 2'd0;
    end else begin
      case (state)
        LOAD:    if (in_valid) cnt <= cnt + 3'd1;
        COMPUTE: begin
          bfly <= bfly + 2'd1;
          if (bfly == 2'd3) stage <= (stage == 2'd2) ? 2'd0 : stage + 2'd1;
        end
        OUTPUT:  if (out_ready) cnt <= cnt + 3'd1;
        default: ;
      endcase
    end
  end

  // Butterfly addressing: top = ((b>>s)<<(s+1)) + (b & (span-1)), k = pos << (2-s).
  always_comb begin
    top  = 3'd0;
    bot  = 3'd1;
    tw_k = 2'd0;
    case (stage)
      2'd0: begin
        top  = {bfly, 1'b0};
        bot  = {bfly, 1'b1};
        tw_k = 2'd0;
      end
      2'd1: begin
        top  = {bfly[1], 1'b0, bfly[0]};
        bot  = {bfly[1], 1'b1, bfly[0]};
        tw_k = {bfly[0], 1'b0};
      end
      default: begin
        top  = {1'b0, bfly};
        bot  = {1'b1, bfly};
        tw_k = bfly;
      end
    endcase
  end

  always_comb begin
    w_re = W_ONE;
    w_im = '0;
    case (tw_k)
      2'd0: begin w_re = W_ONE;  w_im = '0;     end
      2'd1: begin w_re = W_RT;   w_im = W_NRT;  end
      2'd2: begin w_re = '0;     w_im = W_NONE; end
      default: begin w_re = W_NRT; w_im = W_NRT; end
    endcase
  end

  always_comb begin
    a_re = mem_re[top];
    a_im = mem_im[top];
    b_re = mem_re[bot];
    b_im = mem_im[bot];
    t_re = qmul(b_re, w_re) - qmul(b_im, w_im);
    t_im = qmul(b_re, w_im) + qmul(b_im, w_re);
  end

  // Buffer holds no reset: every frame rewrites all eight entries before use.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) begin
      mem_re[{cnt[0], cnt[1], cnt[2]}] <= in_re;
      mem_im[{cnt[0], cnt[1], cnt[2]}] <= in_im;
    end else if (state == COMPUTE) begin
      mem_re[top] <= a_re + t_re;
      mem_im[top] <= a_im + t_im;
      mem_re[bot] <= a_re - t_re;
      mem_im[bot] <= a_im - t_im;
    end
  end

endmodule

// File: tb/tb_fft8_seq.sv
// Scoreboard bench for fft8_seq: stimulus pushes expected bins, a negedge monitor pops and compares.
module tb_fft8_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_re, in_im;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_re, out_im;
  logic        out_last;
  logic        busy;

  fft8_seq #(.DATA_W(32), .FRAC_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int n_xfer = 0;
  logic [64:0] exp_q[$];
  logic signed [31:0] fr [8];
  logic signed [31:0] fi [8];
  logic signed [31:0] twr [4] = '{32'h00010000, 32'h0000B504, 32'h00000000, 32'hFFFF4AFC};
  logic signed [31:0] twi [4] = '{32'h00000000, 32'hFFFF4AFC, 32'hFFFF0000, 32'hFFFF4AFC};

  logic        held_v = 1'b0;
  logic [31:0] held_re, held_im;
  logic        held_last;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, req);
    end
  endtask

  function automatic logic signed [31:0] qm(input logic signed [31:0] a, input logic signed [31:0] b);
    longint p;
    p = longint'(a) * longint'(b);
    return 32'(p >>> 16);
  endfunction

  task automatic push_exp(input logic [31:0] re, input logic [31:0] im, input logic last);
    exp_q.push_back({last, re, im});
  endtask

  // Golden FFT: textbook iterative DIT over the fr/fi frame.
  task automatic push_model();
    logic signed [31:0] ar [8];
    logic signed [31:0] ai [8];
    logic signed [31:0] tr, ti, ur, ui;
    logic [2:0] nb;
    for (int n = 0; n < 8; n++) begin
      nb = n[2:0];
      ar[{nb[0], nb[1], nb[2]}] = fr[n];
      ai[{nb[0], nb[1], nb[2]}] = fi[n];
    end
    for (int len = 2; len <= 8; len = len * 2)
      for (int st = 0; st < 8; st += len)
        for (int j = 0; j < len / 2; j++) begin
          int k, p, q;
          k = j * (8 / len);
          p = st + j;
          q = p + len / 2;
          tr = qm(ar[q], twr[k]) - qm(ai[q], twi[k]);
          ti = qm(ar[q], twi[k]) + qm(ai[q], twr[k]);
          ur = ar[p];
          ui = ai[p];
          ar[p] = ur + tr;
          ai[p] = ui + ti;
          ar[q] = ur - tr;
          ai[q] = ui - ti;
        end
    for (int k = 0; k < 8; k++) push_exp(ar[k], ai[k], k == 7);
  endtask

  task automatic set_frame_impulse(input int pos);
    for (int n = 0; n < 8; n++) begin
      fr[n] = (n == pos) ? 32'sh00010000 : 32'sh0;
      fi[n] = 32'sh0;
    end
  endtask

  task automatic set_frame_dc();
    for (int n = 0; n < 8; n++) begin
      fr[n] = 32'sh00010000;
      fi[n] = 32'sh0;
    end
  endtask

  task automatic send_frame();
    for (int n = 0; n < 8; n++) begin
      int w;
      w = 0;
      while (!in_ready && w < 60) begin
        @(posedge clk); #1;
        w++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      in_valid = 1'b1;
      in_re = fr[n];
      in_im = fi[n];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_q.size() != 0 || !in_ready) && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    check("in_ready_after_frame", 64'(in_ready), 64'd1);
  endtask

  task automatic wait_xfer(input int target);
    int w;
    w = 0;
    while (n_xfer < target && w < 60) begin
      @(posedge clk); #1;
      w++;
    end
    check("reach_bin", 64'(n_xfer), 64'(target));
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: decoupled from stimulus, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", 64'(out_valid), 64'd1);
        check("hold_re", 64'(out_re), 64'(held_re));
        check("hold_im", 64'(out_im), 64'(held_im));
        check("hold_last", 64'(out_last), 64'(held_last));
      end
      if (!out_valid) begin
        check("idle_data_zero", {out_re, out_im}, 64'd0);
      end else begin
        check("in_ready_low_in_output", 64'(in_ready), 64'd0);
        check("busy_in_output", 64'(busy), 64'd1);
      end
      if (out_valid && out_ready) begin
        logic [64:0] e;
        check("bin_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("bin_re", 64'(out_re), 64'(e[63:32]));
          check("bin_im", 64'(out_im), 64'(e[31:0]));
          check("bin_last", 64'(out_last), 64'(e[64]));
        end
        n_xfer++;
      end
      held_v    = out_valid && !out_ready;
      held_re   = out_re;
      held_im   = out_im;
      held_last = out_last;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int start;
    rst = 1'b1;
    in_valid = 1'b0;
    in_re = '0;
    in_im = '0;
    out_ready = 1'b1;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_out_last", 64'(out_last), 64'd0);
    check("reset_out_data", {out_re, out_im}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Impulse at n=0: flat spectrum, plus latency from last input.
    set_frame_impulse(0);
    for (int k = 0; k < 8; k++) push_exp(32'h00010000, 32'h0, k == 7);
    send_frame();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    check("first_valid_latency_edges", 64'(lat), 64'd12);
    wait_drain();

    // DC frame.
    set_frame_dc();
    push_exp(32'h00080000, 32'h0, 1'b0);
    for (int k = 1; k < 8; k++) push_exp(32'h0, 32'h0, k == 7);
    send_frame();
    wait_drain();

    // Impulse at n=1: bins are the twiddle powers.
    set_frame_impulse(1);
    push_exp(32'h00010000, 32'h00000000, 1'b0);
    push_exp(32'h0000B504, 32'hFFFF4AFC, 1'b0);
    push_exp(32'h00000000, 32'hFFFF0000, 1'b0);
    push_exp(32'hFFFF4AFC, 32'hFFFF4AFC, 1'b0);
    push_exp(32'hFFFF0000, 32'h00000000, 1'b0);
    push_exp(32'hFFFF4AFC, 32'h0000B504, 1'b0);
    push_exp(32'h00000000, 32'h00010000, 1'b0);
    push_exp(32'h0000B504, 32'h0000B504, 1'b1);
    send_frame();
    wait_drain();

    // Mixed frame with a 5-cycle stall on bin 3.
    fr = '{32'sh00012345, 32'shFFFE8000, 32'sh00030000, 32'sh00004000,
           32'shFFFF0001, 32'sh00007FFF, 32'sh00021111, 32'shFFFFC000};
    fi = '{32'sh00000000, 32'sh0000A000, 32'shFFFF7777, 32'sh00015555,
           32'sh00000003, 32'shFFFE0000, 32'sh00001234, 32'sh0002ABCD};
    push_model();
    start = n_xfer;
    send_frame();
    wait_xfer(start + 3);
    out_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("stall_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    wait_drain();
    check("stall_bin_count", 64'(n_xfer - start), 64'd8);

    // Reset during compute (6 butterflies done).
    set_frame_dc();
    send_frame();
    repeat (6) @(posedge clk);
    #1;
    check("busy_mid_compute", 64'(busy), 64'd1);
    async_reset();

    // Reset while presenting bin 4.
    set_frame_impulse(0);
    for (int k = 0; k < 8; k++) push_exp(32'h00010000, 32'h0, k == 7);
    start = n_xfer;
    send_frame();
    wait_xfer(start + 4);
    async_reset();
    repeat (20) @(posedge clk);
    #1;
    check("no_stale_output", 64'(n_xfer - start), 64'd4);

    // Fresh DC frame after the aborted ones.
    set_frame_dc();
    push_exp(32'h00080000, 32'h0, 1'b0);
    for (int k = 1; k < 8; k++) push_exp(32'h0, 32'h0, k == 7);
    send_frame();
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
